// File: rtl/alice_qubit_tx.sv
// BB84 transmitter: draws bit/basis pairs from a Galois LFSR, ships them as qubits
// over a valid/ready channel, then sifts the stored frame against Bob's bases.
//
// state | meaning
// IDLE  | waiting for start; sifted_count holds last frame's result
// SEND  | presenting qubit tx_idx, recording it on each accepted transfer
// SIFT  | consuming Bob's bases in order, emitting key bits on basis match
// DONE  | one-cycle end-of-frame pulse, always returns to IDLE
module alice_qubit_tx #(
  parameter int          FRAME_LEN = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] qubit_out,
  output logic       qubit_valid,
  input  logic       qubit_ready,
  input  logic       bob_basis,
  input  logic       bob_basis_valid,
  output logic       key_bit,
  output logic       key_valid,
  output logic [8:0] sifted_count,
  output logic       busy,
  output logic       done
);

  localparam int              IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [15:0]     TAP_MASK = 16'hB400;
  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0]     SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_SIFT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          lfsr_next;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [FRAME_LEN-1:0] bit_mem_q, bit_mem_d;
  logic [FRAME_LEN-1:0] basis_mem_q, basis_mem_d;
  logic                 key_bit_q, key_bit_d;
  logic                 key_valid_q, key_valid_d;
  logic [8:0]           sifted_count_q, sifted_count_d;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAP_MASK : 16'h0000);

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    tx_idx_d       = tx_idx_q;
    rx_idx_d       = rx_idx_q;
    bit_mem_d      = bit_mem_q;
    basis_mem_d    = basis_mem_q;
    key_bit_d      = key_bit_q;
    key_valid_d    = 1'b0;
    sifted_count_d = sifted_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_SEND;
          tx_idx_d       = '0;
          rx_idx_d       = '0;
          sifted_count_d = '0;
        end
      end

      S_SEND: begin
        // qubit_valid is implied by the state, so ready alone completes a transfer.
        if (qubit_ready) begin
          bit_mem_d[tx_idx_q]   = lfsr_q[0];
          basis_mem_d[tx_idx_q] = lfsr_q[1];
          lfsr_d                = lfsr_next;
          if (tx_idx_q == LAST_IDX) begin
            state_d  = S_SIFT;
            tx_idx_d = '0;
          end else begin
            tx_idx_d = tx_idx_q + IDX_ONE;
          end
        end
      end

      S_SIFT: begin
        if (bob_basis_valid) begin
          if (bob_basis == basis_mem_q[rx_idx_q]) begin
            key_valid_d    = 1'b1;
            key_bit_d      = bit_mem_q[rx_idx_q];
            sifted_count_d = sifted_count_q + 9'd1;
          end
          if (rx_idx_q == LAST_IDX) begin
            state_d  = S_DONE;
            rx_idx_d = '0;
          end else begin
            rx_idx_d = rx_idx_q + IDX_ONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED_EFF;
      tx_idx_q       <= '0;
      rx_idx_q       <= '0;
      bit_mem_q      <= '0;
      basis_mem_q    <= '0;
      key_bit_q      <= 1'b0;
      key_valid_q    <= 1'b0;
      sifted_count_q <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      tx_idx_q       <= tx_idx_d;
      rx_idx_q       <= rx_idx_d;
      bit_mem_q      <= bit_mem_d;
      basis_mem_q    <= basis_mem_d;
      key_bit_q      <= key_bit_d;
      key_valid_q    <= key_valid_d;
      sifted_count_q <= sifted_count_d;
    end
  end

  // Qubit encoding {bit, basis}: 00 zero, 01 plus, 10 one, 11 minus.
  assign qubit_valid  = (state_q == S_SEND);
  assign qubit_out    = qubit_valid ? {lfsr_q[0], lfsr_q[1]} : 2'b00;
  assign busy         = (state_q == S_SEND) || (state_q == S_SIFT);
  assign done         = (state_q == S_DONE);
  assign key_bit      = key_bit_q;
  assign key_valid    = key_valid_q;
  assign sifted_count = sifted_count_q;

endmodule
